// File: rtl/vend_pkg.sv
// Shared constants, codes and state type for the vend controller.
// Refund-on-cancel path is compiled in with VEND_CANCEL_EN.
package vend_pkg;

  localparam int NUM_PRODUCTS = 4;

  localparam int unsigned D500  = 500;
  localparam int unsigned D1000 = 1000;
  localparam int unsigned D2000 = 2000;
  localparam int unsigned D5000 = 5000;

  localparam logic [3:0] C500  = 4'b0001;
  localparam logic [3:0] C1000 = 4'b0010;
  localparam logic [3:0] C2000 = 4'b0100;
  localparam logic [3:0] C5000 = 4'b1000;

  localparam logic [3:0] ERR_NONE    = 4'b0000;
  localparam logic [3:0] ERR_PRODUCT = 4'b0001;
  localparam logic [3:0] ERR_CREDIT  = 4'b0010;
  localparam logic [3:0] ERR_CHANGE  = 4'b0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DISPENSE,
    S_CHANGE,
    S_FINISH,
    S_FAIL
  } state_t;

  function automatic int unsigned price(input logic [2:0] sel);
    case (sel)
      3'd0:    price = 1500;
      3'd1:    price = 2000;
      3'd2:    price = 3500;
      3'd3:    price = 5000;
      default: price = 0;
    endcase
  endfunction

  function automatic int unsigned coin_value(input logic [3:0] c);
    case (c)
      C500:    coin_value = D500;
      C1000:   coin_value = D1000;
      C2000:   coin_value = D2000;
      C5000:   coin_value = D5000;
      default: coin_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_if.sv
// Upstream/downstream signal bundle of the vend controller.
// master drives requests and credit, slave is the controller.
interface vend_if #(
  parameter int CNT_W = 8,
  parameter int VAL_W = 16
);
  logic [VAL_W-1:0] total;
  logic [CNT_W-1:0] num_500;
  logic [CNT_W-1:0] num_1000;
  logic [CNT_W-1:0] num_2000;
  logic [CNT_W-1:0] num_5000;
  logic             select_valid;
  logic [2:0]       product_sel;
  logic             cancel;
  logic             busy;
  logic             dispense;
  logic [2:0]       product_id;
  logic [3:0]       coin_out;
  logic [VAL_W-1:0] remaining;
  logic             credit_clear;
  logic             done;
  logic [3:0]       error;

  modport master (
    output total, num_500, num_1000, num_2000, num_5000,
    output select_valid, product_sel, cancel,
    input  busy, dispense, product_id, coin_out,
    input  remaining, credit_clear, done, error
  );

  modport slave (
    input  total, num_500, num_1000, num_2000, num_5000,
    input  select_valid, product_sel, cancel,
    output busy, dispense, product_id, coin_out,
    output remaining, credit_clear, done, error
  );
endinterface

// File: rtl/change_selector.sv
// Greedy largest-first change coin pick; 0000 when nothing fits.
module change_selector
  import vend_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int VAL_W = 16
) (
  input  logic [VAL_W-1:0] remaining,
  input  logic [CNT_W-1:0] num_500,
  input  logic [CNT_W-1:0] num_1000,
  input  logic [CNT_W-1:0] num_2000,
  input  logic [CNT_W-1:0] num_5000,
  output logic [3:0]       pick
);

  logic [3:0] fit;

  assign fit[3] = (num_5000 != '0) && (remaining >= VAL_W'(D5000));
  assign fit[2] = (num_2000 != '0) && (remaining >= VAL_W'(D2000));
  assign fit[1] = (num_1000 != '0) && (remaining >= VAL_W'(D1000));
  assign fit[0] = (num_500  != '0) && (remaining >= VAL_W'(D500));

  always_comb begin
    pick = 4'b0000;
    priority case (1'b1)
      fit[3]:  pick = C5000;
      fit[2]:  pick = C2000;
      fit[1]:  pick = C1000;
      fit[0]:  pick = C500;
      default: pick = 4'b0000;
    endcase
  end

endmodule

// File: rtl/vend_controller.sv
// Vend/change stage: price check, dispense pulse, greedy change payout.
// Define VEND_CANCEL_EN to enable the cancel/refund path.
module vend_controller
  import vend_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int VAL_W = 16
) (
  input  logic clock,
  input  logic reset_n,
  vend_if.slave bus
);

  state_t           state;
  state_t           state_d;
  logic [VAL_W-1:0] total_q;
  logic [VAL_W-1:0] remaining_q;
  logic [VAL_W-1:0] price_v;
  logic [VAL_W-1:0] coin_amt;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [3:0]       error_q;
  logic [3:0]       pick;
  logic             refund;
  logic             start;
  logic             invalid;
  logic             short_credit;

`ifdef VEND_CANCEL_EN
  assign refund = bus.cancel && (bus.total != '0);
`else
  assign refund = 1'b0;
`endif

  assign start        = bus.select_valid || refund;
  assign price_v      = VAL_W'(price(sel_q));
  assign invalid      = int'(sel_q) >= NUM_PRODUCTS;
  assign short_credit = total_q < price_v;
  assign coin_amt     = VAL_W'(coin_value(pick));

  change_selector #(
    .CNT_W(CNT_W),
    .VAL_W(VAL_W)
  ) u_sel (
    .remaining(remaining_q),
    .num_500  (cnt_q[0]),
    .num_1000 (cnt_q[1]),
    .num_2000 (cnt_q[2]),
    .num_5000 (cnt_q[3]),
    .pick     (pick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (refund)                state_d = S_CHANGE;
        else if (bus.select_valid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (invalid || short_credit) state_d = S_FAIL;
        else                         state_d = S_DISPENSE;
      end
      S_DISPENSE: begin
        if (remaining_q != '0) state_d = S_CHANGE;
        else                   state_d = S_FINISH;
      end
      S_CHANGE: begin
        if (pick == 4'b0000 || coin_amt == remaining_q)
          state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      total_q     <= '0;
      remaining_q <= '0;
      sel_q       <= '0;
      error_q     <= ERR_NONE;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            total_q  <= bus.total;
            sel_q    <= bus.product_sel;
            error_q  <= ERR_NONE;
            cnt_q[0] <= bus.num_500;
            cnt_q[1] <= bus.num_1000;
            cnt_q[2] <= bus.num_2000;
            cnt_q[3] <= bus.num_5000;
          end
          if (refund) remaining_q <= bus.total;
        end
        S_CHECK: begin
          if (invalid)           error_q <= ERR_PRODUCT;
          else if (short_credit) error_q <= ERR_CREDIT;
          else remaining_q <= total_q - price_v;
        end
        S_CHANGE: begin
          // No fit: keep remaining as the amount still owed
          if (pick == 4'b0000) begin
            error_q <= ERR_CHANGE;
          end else begin
            remaining_q <= remaining_q - coin_amt;
            for (int i = 0; i < 4; i++)
              if (pick[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = state != S_IDLE;
  assign bus.dispense     = state == S_DISPENSE;
  assign bus.product_id   = sel_q;
  assign bus.coin_out     = (state == S_CHANGE) ? pick : 4'b0000;
  assign bus.remaining    = remaining_q;
  assign bus.credit_clear = state == S_FINISH;
  assign bus.done         = (state == S_FINISH) || (state == S_FAIL);
  assign bus.error        = error_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller with a greedy-change reference model.
// Reference honours VEND_CANCEL_EN the same way as the build.
module tb_vend_controller;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  vend_if #(.CNT_W(8), .VAL_W(16)) bus ();

  vend_controller #(.CNT_W(8), .VAL_W(16)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         disp;
    logic [2:0] pid;
    int         ncoins;
    logic [3:0] err;
    int         rem;
    bit         clr;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] coin_q[$];
  exp_t       e_m;
  int         n_tests = 0;
  int         n_fail = 0;
  int         last_rem = 0;
  int         obs_n = 0;
  bit         obs_disp = 0;
  logic [2:0] obs_pid = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int price_of(input int sel);
    int p[4] = '{1500, 2000, 3500, 5000};
    return p[sel];
  endfunction

  task automatic predict(input int total, input int sel,
                         input int c5, input int c10,
                         input int c20, input int c50,
                         input bit cxl,
                         output bit disp, output bit rf);
    exp_t e;
    int owed;
    int k;
    int cnt[4];
    int val[4] = '{5000, 2000, 1000, 500};
    logic [3:0] code[4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    cnt = '{c50, c20, c10, c5};
    e.disp = 0; e.pid = 3'(sel); e.ncoins = 0;
    e.err = 0; e.rem = last_rem; e.clr = 0;
    owed = -1;
    rf = 0;
`ifdef VEND_CANCEL_EN
    if (cxl && total > 0) begin
      rf = 1;
      owed = total;
    end
`else
    if (cxl) rf = 0;
`endif
    if (!rf) begin
      if (sel >= 4) e.err = 4'b0001;
      else if (total < price_of(sel)) e.err = 4'b0010;
      else begin
        e.disp = 1;
        owed = total - price_of(sel);
      end
    end
    if (owed >= 0) begin
      e.clr = 1;
      while (owed > 0) begin
        k = -1;
        for (int i = 0; i < 4; i++)
          if (k < 0 && cnt[i] > 0 && val[i] <= owed) k = i;
        if (k < 0) begin
          e.err = 4'b0100;
          break;
        end
        coin_q.push_back(code[k]);
        cnt[k]--;
        owed -= val[k];
        e.ncoins++;
      end
      e.rem = owed;
    end
    last_rem = e.rem;
    disp = e.disp;
    exp_q.push_back(e);
  endtask

  task automatic scramble();
    bus.total        = 16'($urandom);
    bus.num_500      = 8'($urandom);
    bus.num_1000     = 8'($urandom);
    bus.num_2000     = 8'($urandom);
    bus.num_5000     = 8'($urandom);
    bus.product_sel  = 3'($urandom);
    bus.select_valid = 1'($urandom);
    bus.cancel       = 1'($urandom);
  endtask

  task automatic drive(input int total, input int sel,
                       input int c5, input int c10,
                       input int c20, input int c50,
                       input bit cxl,
                       output bit disp, output bit rf);
    predict(total, sel, c5, c10, c20, c50, cxl, disp, rf);
    bus.total        = 16'(total);
    bus.product_sel  = 3'(sel);
    bus.num_500      = 8'(c5);
    bus.num_1000     = 8'(c10);
    bus.num_2000     = 8'(c20);
    bus.num_5000     = 8'(c50);
    bus.cancel       = cxl;
    bus.select_valid = 1'b1;
  endtask

  task automatic run_txn(input int total, input int sel,
                         input int c5, input int c10,
                         input int c20, input int c50,
                         input bit cxl);
    bit disp;
    bit rf;
    int k;
    drive(total, sel, c5, c10, c20, c50, cxl, disp, rf);
    @(negedge clock);
    scramble();
    @(negedge clock);
    if (!rf) check("latency", disp ? bus.dispense : bus.done, 1);
    scramble();
    k = 0;
    while (bus.busy && k < 300) begin
      @(negedge clock);
      scramble();
      k++;
    end
    check("back_to_idle", bus.busy, 0);
    bus.select_valid = 1'b0;
    bus.cancel       = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      obs_n    = 0;
      obs_disp = 0;
    end else begin
      if (bus.dispense) begin
        obs_disp = 1;
        obs_pid  = bus.product_id;
      end
      if (bus.coin_out != 4'b0000) begin
        obs_n++;
        check("coin_expected", coin_q.size() != 0, 1);
        if (coin_q.size() != 0) check("coin_out", bus.coin_out, coin_q.pop_front());
      end
      if (bus.credit_clear) check("clear_with_done", bus.done, 1);
      if (bus.done) begin
        check("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_m = exp_q.pop_front();
          check("dispense_seen", obs_disp, e_m.disp);
          if (e_m.disp) check("product_id", obs_pid, e_m.pid);
          check("coin_count", obs_n, e_m.ncoins);
          check("credit_clear", bus.credit_clear, e_m.clr);
          check("error", bus.error, e_m.err);
          check("remaining", bus.remaining, e_m.rem);
        end
        obs_n    = 0;
        obs_disp = 0;
      end
    end
  end

  typedef struct {
    int total; int sel; int c5; int c10; int c20; int c50; bit cxl;
  } vec_t;

  vec_t dir[8] = '{
    '{2000,  0, 4, 0, 0, 0, 0},
    '{10000, 2, 2, 1, 0, 1, 0},
    '{1000,  1, 3, 3, 3, 3, 0},
    '{3000,  5, 3, 3, 3, 3, 0},
    '{8000,  1, 0, 0, 3, 1, 0},
    '{1500,  0, 3, 1, 0, 0, 1},
    '{3500,  2, 0, 0, 0, 0, 0},
    '{0,     0, 1, 1, 1, 1, 0}
  };

  initial begin
    bit disp;
    bit rf;
    int n;
    int k;
    int t;
    bus.total = '0; bus.product_sel = '0;
    bus.num_500 = '0; bus.num_1000 = '0;
    bus.num_2000 = '0; bus.num_5000 = '0;
    bus.select_valid = 1'b0; bus.cancel = 1'b0;
    #12;
    check("reset_busy_dispense_done",
          {bus.busy, bus.dispense, bus.done, bus.credit_clear}, 0);
    check("reset_coin_error", {bus.coin_out, bus.error}, 0);
    check("reset_remaining_pid", {bus.remaining, bus.product_id}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    foreach (dir[i])
      run_txn(dir[i].total, dir[i].sel, dir[i].c5, dir[i].c10,
              dir[i].c20, dir[i].c50, dir[i].cxl);

    // Abort a long payout with an asynchronous reset
    drive(20000, 0, 40, 0, 0, 0, 0, disp, rf);
    @(negedge clock);
    bus.select_valid = 1'b0;
    n = 0;
    k = 0;
    while (n < 3 && k < 100) begin
      @(negedge clock);
      if (bus.coin_out != 4'b0000) n++;
      k++;
    end
    check("reached_change", n, 3);
    #1 reset_n = 1'b0;
    #1;
    check("abort_busy_dispense_done",
          {bus.busy, bus.dispense, bus.done, bus.credit_clear}, 0);
    check("abort_coin_error", {bus.coin_out, bus.error}, 0);
    check("abort_remaining", bus.remaining, 0);
    exp_q.delete();
    coin_q.delete();
    last_rem = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 40; i++) begin
      t = $urandom_range(0, 24) * 500;
      if ($urandom_range(0, 3) == 0) t += $urandom_range(0, 499);
      run_txn(t, $urandom_range(0, 5),
              $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4),
              1'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clock);
    check("exp_drained", exp_q.size(), 0);
    check("coins_drained", coin_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Sequential vend/change stage directly downstream of the money-input block. It consumes the accumulated credit and per-denomination coin counts, and accepts a product selection. It checks price against credit, pulses a dispense strobe, then pays change one coin per cycle with a greedy largest-first pick. On completion it clears upstream credit.

## Interface
Parameters:
- `CNT_W`, default 8: width of the coin-count inputs.
- `VAL_W`, default 16: width of credit and remaining values.

Ports:
- `clock`: input, 1 bit. Single clock. One clock; reset is asynchronous and active-low.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `total`: input, `VAL_W`. Credit from upstream.
- `num_500`, `num_1000`, `num_2000`, `num_5000`: inputs, `CNT_W` each. Available coins/notes per denomination.
- `select_valid`: input, 1 bit. Selection request, sampled only in IDLE.
- `product_sel`: input, 3 bits. Product index.
- `cancel`: input, 1 bit. Refund request (see Configuration).
- `busy`: output, 1 bit. High in every state except IDLE.
- `dispense`: output, 1 bit. One-cycle product-release pulse.
- `product_id`: output, 3 bits. Latched selection, valid while `dispense` is high.
- `coin_out`: output, 4 bits. One-hot change coin, one cycle per coin. Encoding: 0001=500, 0010=1000, 0100=2000, 1000=5000.
- `remaining`: output, `VAL_W`. Change still owed.
- `credit_clear`: output, 1 bit. One-cycle pulse to the upstream reset/clear.
- `done`: output, 1 bit. One-cycle pulse marking transaction end.
- `error`: output, 4 bits.
  - 0001: invalid product.
  - 0010: insufficient credit.
  - 0100: cannot make change.

## Operation
- States: IDLE, CHECK, DISPENSE, CHANGE, FINISH, FAIL.
- **IDLE**
  - On `select_valid`: latch `total`, `product_sel`, and all four counts into local copies. Clear `error`. Go to CHECK.
  - `cancel` has priority over `select_valid` (when enabled).
- **CHECK**
  - `product_sel` ≥ `NUM_PRODUCTS`: set `error`=0001, go to FAIL.
  - Else if latched total < `PRICE[sel]`: set `error`=0010, go to FAIL.
  - Else: `remaining` ← total − price, go to DISPENSE.
- **DISPENSE**
  - Assert `dispense` for one cycle.
  - Go to CHANGE if `remaining` > 0, else go to FINISH.
- **CHANGE**, each cycle:
  - Pick the largest denomination d with d ≤ `remaining` and local count > 0.
  - Emit its one-hot code on `coin_out`, decrement that local count, and set `remaining` ← `remaining` − d.
  - If `remaining` reaches 0, go to FINISH.
  - If no denomination fits, set `error`=0100, hold `remaining` (amount owed), and go to FINISH.
- **FINISH**: pulse `credit_clear` and `done` for one cycle, then go to IDLE.
- **FAIL**: pulse `done` only, with no `credit_clear`, so credit is retained. Then go to IDLE.
- Greedy choice is required even where a non-greedy combination would succeed (e.g. 6000 owed with 5000×1 and 2000×3 available → 5000 is paid, then error 0100 with 1000 owed).
- Arithmetic is unsigned, `VAL_W` bits. Subtraction happens only after the ≥ check, so it never underflows.
- Input changes while `busy` is high are ignored; only the latched copies are used.
- `error` and `remaining` hold their values until the next accepted request.

## Timing
- Reset values: all outputs 0 and state IDLE. Reset mid-transaction aborts immediately: no further pulses are issued, and credit is not cleared.
- Latency from `select_valid` to `dispense`:
  - 2 cycles: accept, then CHECK.
  - `dispense` is high in the 3rd cycle after the accept edge.
- Change: one coin per cycle, starting the cycle after `dispense`. N coins take N cycles; FINISH follows one cycle later.
- FAIL: `done` is high 2 cycles after accept. `busy` drops the following cycle.
- `select_valid` asserted in the same cycle that FINISH/FAIL returns to IDLE is not accepted. It is accepted on the next IDLE cycle.

## Configuration
- `VEND_CANCEL_EN` defined:
  - `cancel` in IDLE with `total` > 0 sets `remaining` ← `total` and enters CHANGE directly, with no dispense.
  - Completion is via FINISH, so `credit_clear` is pulsed.
  - `cancel` with `total`=0 is ignored.
- Undefined: the `cancel` port exists but is ignored, and no refund path is synthesised.

## Structure
- `vend_pkg` holds:
  - `NUM_PRODUCTS`=4.
  - `PRICE` constants: 1500, 2000, 3500, 5000.
  - Denomination values and one-hot codes.
  - Error codes.
  - The state enum.
- Sub-module `change_selector`: combinational. Takes `remaining` and the four local counts, outputs the one-hot pick (0000 means none fits). It is instantiated once in CHANGE.

## Test plan
- Reset, then `total`=2000, sel 0: `dispense` in cycle 3, one `coin_out`=0001, `credit_clear`/`done`, `remaining`=0.
- `total`=10000, sel 2, counts 5000×1 / 1000×1 / 500×2: change 6500 paid as 5000, 1000, 500 on consecutive cycles.
- `total`=1000, sel 1: `error`=0010, `done` without `credit_clear`, no `dispense`.
- `product_sel`=5: `error`=0001. Then a `select_valid` during busy is ignored.
- `total`=8000, sel 1, counts 5000×1 / 2000×3 / others 0: 5000 paid, then `error`=0100 with `remaining`=1000.
- With `VEND_CANCEL_EN`, `total`=1500, `cancel`+`select_valid` together: refund 1000+500, no `dispense`. Reset asserted mid-CHANGE: all outputs go to 0 immediately.
